ifu_lsu_rd_arb: RTL and testbench

Shares the single core AXI read port between the instruction-fetch master (port s0, IFU) and the load/store master (port s1, LSU). Arbitrates AR requests with round-robin priority and tags each downstream ARID with the source. Routes R beats back by RID and tracks outstanding bursts per source. Sits between the IFU/LSU AXI masters and the core-level AXI interconnect.

---
 rtl/ifu_lsu_rd_arb_if.sv | 26 ++
 rtl/ifu_lsu_rd_arb.sv | 125 ++++++++++++
 tb/tb_ifu_lsu_rd_arb.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_lsu_rd_arb_if.sv
// AXI read-channel bundle (AR + R). It is used for the IFU and LSU upstream ports
// and for the core-side downstream port of the read arbiter.
interface ifu_lsu_rd_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  input  arready, rid, rdata, rresp, rlast, rvalid);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/ifu_lsu_rd_arb.sv
// Round-robin AR arbiter between IFU (s0) and LSU (s1) onto one AXI read port.
// ARID bit 0 carries the source; R beats are routed back on RID bit 0.
module ifu_lsu_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2,
  parameter int OSTD   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ifu_lsu_rd_arb_if.slave   s0,
  ifu_lsu_rd_arb_if.slave   s1,
  ifu_lsu_rd_arb_if.master  m
);
  localparam int               CNT_W   = $clog2(OSTD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSTD);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q;
  logic              rr_q;
  logic              arvalid_q;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [DATA_W-1:0] rdata_fan;

  logic elig0, elig1, both, gnt0, gnt1;
  logic ar_hs, r_end, inc0, inc1, dec0, dec1;
  logic unused_ok;

  assign elig0 = s0.arvalid & (cnt0_q != CNT_MAX);
  assign elig1 = s1.arvalid & (cnt1_q != CNT_MAX);
  assign both  = elig0 & elig1;
  // rr_q names the source that wins a tie; gated by rst_n so no accept shows during reset
  assign gnt0  = rst_n & (state_q == IDLE) & elig0 & (~elig1 | ~rr_q);
  assign gnt1  = rst_n & (state_q == IDLE) & elig1 & (~elig0 |  rr_q);

  assign s0.arready = gnt0;
  assign s1.arready = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            state_q   <= ISSUE;
            arvalid_q <= 1'b1;
            arid_q    <= ID_W'(gnt1);
            araddr_q  <= gnt1 ? s1.araddr : s0.araddr;
            arlen_q   <= gnt1 ? s1.arlen  : s0.arlen;
            if (both) rr_q <= ~rr_q;
          end
        end
        ISSUE: begin
          if (m.arready) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m.arid    = arid_q;
  assign m.araddr  = araddr_q;
  assign m.arlen   = arlen_q;
  assign m.arsize  = 3'b010;
  assign m.arburst = 2'b01;
  assign m.arvalid = arvalid_q;

  // Outstanding-burst accounting; a stray rlast at zero is dropped rather than wrapping
  assign ar_hs = (state_q == ISSUE) & arvalid_q & m.arready;
  assign r_end = m.rvalid & m.rready & m.rlast;
  assign inc0  = ar_hs & ~arid_q[0];
  assign inc1  = ar_hs &  arid_q[0];
  assign dec0  = r_end & ~m.rid[0] & (cnt0_q != '0);
  assign dec1  = r_end &  m.rid[0] & (cnt1_q != '0);

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (inc0 & ~dec0)      cnt0_d = cnt0_q + CNT_W'(1);
    else if (dec0 & ~inc0) cnt0_d = cnt0_q - CNT_W'(1);
    if (inc1 & ~dec1)      cnt1_d = cnt1_q + CNT_W'(1);
    else if (dec1 & ~inc1) cnt1_d = cnt1_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign rdata_fan = m.rdata;
  assign m.rready  = m.rid[0] ? s1.rready : s0.rready;

  assign s0.rvalid = rst_n & m.rvalid & ~m.rid[0];
  assign s1.rvalid = rst_n & m.rvalid &  m.rid[0];
  assign s0.rdata  = rdata_fan;
  assign s1.rdata  = rdata_fan;
  assign s0.rresp  = m.rresp;
  assign s1.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rlast  = m.rlast;
  assign s0.rid    = m.rid;
  assign s1.rid    = m.rid;

  // Upstream ID/size/burst fields are not forwarded; RID bits above 0 are ignored
  assign unused_ok = ^{s0.arid, s0.arsize, s0.arburst,
                       s1.arid, s1.arsize, s1.arburst, m.rid};
endmodule

// File: tb/tb_ifu_lsu_rd_arb.sv
// Bench for ifu_lsu_rd_arb: directed scenarios followed by a randomized run
// against a transaction-level model of arbitration, burst tracking and R routing.
module tb_ifu_lsu_rd_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;
  localparam int OSTD   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ifu_lsu_rd_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s0_if();
  ifu_lsu_rd_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s1_if();
  ifu_lsu_rd_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_if();

  ifu_lsu_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .OSTD(OSTD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s0   (s0_if),
    .s1   (s1_if),
    .m    (m_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    s0_if.arid = '0; s0_if.araddr = '0; s0_if.arlen = '0; s0_if.arsize = '0;
    s0_if.arburst = '0; s0_if.arvalid = 1'b0; s0_if.rready = 1'b1;
    s1_if.arid = '0; s1_if.araddr = '0; s1_if.arlen = '0; s1_if.arsize = '0;
    s1_if.arburst = '0; s1_if.arvalid = 1'b0; s1_if.rready = 1'b1;
    m_if.arready = 1'b0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;
    m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
  endtask

  // One single-beat (rlast) R transfer on the given RID, upstream ready assumed high
  task automatic r_beat(input logic [1:0] id);
    m_if.rvalid = 1'b1; m_if.rid = id; m_if.rlast = 1'b1; m_if.rdata = 32'h0;
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h8000_0000; s0_if.arlen = 8'd0;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h2000_0010; s1_if.arlen = 8'd0;
    m_if.arready = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (s0_if.arready !== 1'b0) begin errors++; $display("FAIL rst_s0_arready got=%b exp=0", s0_if.arready); end
    checks++; if (s1_if.arready !== 1'b0) begin errors++; $display("FAIL rst_s1_arready got=%b exp=0", s1_if.arready); end
    checks++; if (m_if.arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid got=%b exp=0", m_if.arvalid); end
    checks++; if (m_if.arid !== 2'd0) begin errors++; $display("FAIL rst_m_arid got=%h exp=0", m_if.arid); end
    checks++; if (m_if.araddr !== 32'h0) begin errors++; $display("FAIL rst_m_araddr got=%h exp=0", m_if.araddr); end
    checks++; if (m_if.arlen !== 8'h0) begin errors++; $display("FAIL rst_m_arlen got=%h exp=0", m_if.arlen); end
    checks++; if (m_if.arsize !== 3'b010) begin errors++; $display("FAIL const_arsize got=%b exp=010", m_if.arsize); end
    checks++; if (m_if.arburst !== 2'b01) begin errors++; $display("FAIL const_arburst got=%b exp=01", m_if.arburst); end
    tick();
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b1;
    #1;
    checks++; if (s0_if.arready !== 1'b1) begin errors++; $display("FAIL sim1_s0_arready got=%b exp=1", s0_if.arready); end
    checks++; if (s1_if.arready !== 1'b0) begin errors++; $display("FAIL sim1_s1_arready got=%b exp=0", s1_if.arready); end
    tick();
    s0_if.arvalid = 1'b0;
    #1;
    checks++; if (m_if.arvalid !== 1'b1) begin errors++; $display("FAIL sim1_m_arvalid got=%b exp=1", m_if.arvalid); end
    checks++; if (m_if.arid !== 2'd0) begin errors++; $display("FAIL sim1_m_arid got=%h exp=0", m_if.arid); end
    checks++; if (m_if.araddr !== 32'h8000_0000) begin errors++; $display("FAIL sim1_m_araddr got=%h exp=80000000", m_if.araddr); end
    checks++; if (s1_if.arready !== 1'b0) begin errors++; $display("FAIL sim1_issue_s1_arready got=%b exp=0", s1_if.arready); end
    tick();
    #1;
    checks++; if (s1_if.arready !== 1'b1) begin errors++; $display("FAIL sim2_s1_arready got=%b exp=1", s1_if.arready); end
    tick();
    s1_if.arvalid = 1'b0;
    #1;
    checks++; if (m_if.arid !== 2'd1) begin errors++; $display("FAIL sim2_m_arid got=%h exp=1", m_if.arid); end
    checks++; if (m_if.araddr !== 32'h2000_0010) begin errors++; $display("FAIL sim2_m_araddr got=%h exp=20000010", m_if.araddr); end
    tick();
    // second simultaneous pair: the tie now goes to s1
    s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
    #1;
    checks++; if (s1_if.arready !== 1'b1) begin errors++; $display("FAIL sim3_s1_arready got=%b exp=1", s1_if.arready); end
    checks++; if (s0_if.arready !== 1'b0) begin errors++; $display("FAIL sim3_s0_arready got=%b exp=0", s0_if.arready); end
    tick();
    s1_if.arvalid = 1'b0;
    #1;
    checks++; if (m_if.arid !== 2'd1) begin errors++; $display("FAIL sim3_m_arid got=%h exp=1", m_if.arid); end
    tick();
    #1;
    checks++; if (s0_if.arready !== 1'b1) begin errors++; $display("FAIL sim4_s0_arready got=%b exp=1", s0_if.arready); end
    tick();
    s0_if.arvalid = 1'b0;
    #1;
    checks++; if (m_if.arid !== 2'd0) begin errors++; $display("FAIL sim4_m_arid got=%h exp=0", m_if.arid); end
    tick();
    r_beat(2'b00); r_beat(2'b00); r_beat(2'b01); r_beat(2'b01);
  endtask

  task automatic test_single_fetch();
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h8000_0000; s0_if.arlen = 8'd0; m_if.arready = 1'b1;
    #1;
    checks++; if (s0_if.arready !== 1'b1) begin errors++; $display("FAIL single_s0_arready got=%b exp=1", s0_if.arready); end
    tick();
    s0_if.arvalid = 1'b0;
    #1;
    checks++; if (m_if.arvalid !== 1'b1) begin errors++; $display("FAIL single_m_arvalid got=%b exp=1", m_if.arvalid); end
    checks++; if (m_if.arid !== 2'd0) begin errors++; $display("FAIL single_m_arid got=%h exp=0", m_if.arid); end
    tick();
    m_if.rvalid = 1'b1; m_if.rid = 2'd0; m_if.rdata = 32'h0000_0013; m_if.rlast = 1'b1; m_if.rresp = 2'b00;
    #1;
    checks++; if (s0_if.rvalid !== 1'b1) begin errors++; $display("FAIL single_s0_rvalid got=%b exp=1", s0_if.rvalid); end
    checks++; if (s1_if.rvalid !== 1'b0) begin errors++; $display("FAIL single_s1_rvalid got=%b exp=0", s1_if.rvalid); end
    checks++; if (s0_if.rdata !== 32'h13) begin errors++; $display("FAIL single_s0_rdata got=%h exp=13", s0_if.rdata); end
    checks++; if (s0_if.rlast !== 1'b1) begin errors++; $display("FAIL single_s0_rlast got=%b exp=1", s0_if.rlast); end
    checks++; if (m_if.rready !== 1'b1) begin errors++; $display("FAIL single_m_rready got=%b exp=1", m_if.rready); end
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
  endtask

  task automatic test_backpressure();
    m_if.arready = 1'b0;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h2000_0040; s1_if.arlen = 8'd3;
    tick();
    s0_if.arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (m_if.arvalid !== 1'b1) begin errors++; $display("FAIL bp_arvalid cyc=%0d got=%b exp=1", i, m_if.arvalid); end
      checks++; if (m_if.araddr !== 32'h2000_0040) begin errors++; $display("FAIL bp_araddr cyc=%0d got=%h exp=20000040", i, m_if.araddr); end
      checks++; if (m_if.arid !== 2'd1) begin errors++; $display("FAIL bp_arid cyc=%0d got=%h exp=1", i, m_if.arid); end
      checks++; if (m_if.arlen !== 8'd3) begin errors++; $display("FAIL bp_arlen cyc=%0d got=%h exp=3", i, m_if.arlen); end
      checks++; if ({s0_if.arready, s1_if.arready} !== 2'b00) begin errors++; $display("FAIL bp_up_arready cyc=%0d got=%b exp=00", i, {s0_if.arready, s1_if.arready}); end
      tick();
    end
    m_if.arready = 1'b1;
    #1;
    checks++; if (m_if.arvalid !== 1'b1) begin errors++; $display("FAIL bp_hs_arvalid got=%b exp=1", m_if.arvalid); end
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
    tick();
    #1;
    checks++; if (m_if.arvalid !== 1'b0) begin errors++; $display("FAIL bp_after_arvalid got=%b exp=0", m_if.arvalid); end
    tick();
  endtask

  task automatic test_r_backpressure();
    int  beat = 0;
    bit  rdy;
    s0_if.rready = 1'b1;
    for (int cyc = 0; cyc < 12 && beat < 4; cyc++) begin
      rdy = (cyc % 2 == 0);
      s1_if.rready = rdy;
      m_if.rvalid = 1'b1; m_if.rid = (beat == 2) ? 2'b11 : 2'b01;
      m_if.rdata = 32'hA000_0000 + beat; m_if.rlast = (beat == 3);
      #1;
      checks++; if (m_if.rready !== rdy) begin errors++; $display("FAIL rbp_m_rready cyc=%0d got=%b exp=%b", cyc, m_if.rready, rdy); end
      checks++; if (s0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rbp_s0_rvalid cyc=%0d got=%b exp=0", cyc, s0_if.rvalid); end
      checks++; if (s1_if.rvalid !== 1'b1) begin errors++; $display("FAIL rbp_s1_rvalid cyc=%0d got=%b exp=1", cyc, s1_if.rvalid); end
      checks++; if (s1_if.rdata !== 32'hA000_0000 + beat) begin errors++; $display("FAIL rbp_s1_rdata cyc=%0d got=%h exp=%h", cyc, s1_if.rdata, 32'hA000_0000 + beat); end
      if (rdy) beat++;
      tick();
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s1_if.rready = 1'b1;
    checks++; if (beat != 4) begin errors++; $display("FAIL rbp_beats got=%0d exp=4", beat); end
  endtask

  task automatic test_limit();
    m_if.arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s0_if.arvalid = 1'b1; s0_if.araddr = 32'h8000_0100 + 32'(k * 4);
      #1;
      checks++; if (s0_if.arready !== 1'b1) begin errors++; $display("FAIL lim_fill%0d_s0_arready got=%b exp=1", k, s0_if.arready); end
      tick();
      s0_if.arvalid = 1'b0;
      tick();
    end
    s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1; s1_if.araddr = 32'h2000_0080;
    #1;
    checks++; if (s0_if.arready !== 1'b0) begin errors++; $display("FAIL lim_full_s0_arready got=%b exp=0", s0_if.arready); end
    checks++; if (s1_if.arready !== 1'b1) begin errors++; $display("FAIL lim_s1_arready got=%b exp=1", s1_if.arready); end
    tick();
    s1_if.arvalid = 1'b0;
    #1;
    checks++; if (m_if.arid !== 2'd1) begin errors++; $display("FAIL lim_s1_arid got=%h exp=1", m_if.arid); end
    tick();
    m_if.rvalid = 1'b1; m_if.rid = 2'b00; m_if.rlast = 1'b1;
    #1;
    checks++; if (s0_if.arready !== 1'b0) begin errors++; $display("FAIL lim_rlast_cycle_s0_arready got=%b exp=0", s0_if.arready); end
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    checks++; if (s0_if.arready !== 1'b1) begin errors++; $display("FAIL lim_reopen_s0_arready got=%b exp=1", s0_if.arready); end
    tick();
    s0_if.arvalid = 1'b0;
    tick();
    // one legitimate rlast and one stray rlast for s1: the stray one must not wrap
    r_beat(2'b01); r_beat(2'b01);
    for (int k = 0; k < 5; k++) begin
      s1_if.arvalid = 1'b1;
      #1;
      checks++; if (s1_if.arready !== (k < 4)) begin errors++; $display("FAIL lim_s1_fill%0d_arready got=%b exp=%b", k, s1_if.arready, (k < 4)); end
      tick();
      s1_if.arvalid = 1'b0;
      tick();
    end
  endtask

  task automatic test_async_reset();
    r_beat(2'b00);
    m_if.arready = 1'b0;
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h8000_0200;
    #1;
    checks++; if (s0_if.arready !== 1'b1) begin errors++; $display("FAIL ar_pre_s0_arready got=%b exp=1", s0_if.arready); end
    tick();
    s0_if.arvalid = 1'b0;
    #1;
    checks++; if (m_if.arvalid !== 1'b1) begin errors++; $display("FAIL ar_pre_arvalid got=%b exp=1", m_if.arvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_if.arvalid !== 1'b0) begin errors++; $display("FAIL ar_async_arvalid got=%b exp=0", m_if.arvalid); end
    checks++; if (m_if.araddr !== 32'h0) begin errors++; $display("FAIL ar_async_araddr got=%h exp=0", m_if.araddr); end
    tick();
    rst_n = 1'b1; m_if.arready = 1'b1; s1_if.arvalid = 1'b1;
    #1;
    checks++; if (s1_if.arready !== 1'b1) begin errors++; $display("FAIL ar_post_s1_arready got=%b exp=1", s1_if.arready); end
    s1_if.arvalid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int          q0[$];
    int          q1[$];
    int          cnt[2];
    bit          rr, pend, psrc, rv, rsrc, rhi, e0, e1, g0, g1, rdy, last;
    logic [31:0] paddr, rdat;
    logic [7:0]  plen;
    cnt[0] = 0; cnt[1] = 0; rr = 0; pend = 0; psrc = 0; rv = 0; rsrc = 0; rhi = 0;
    paddr = '0; plen = '0; rdat = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      s0_if.arvalid = 1'($urandom_range(0, 1)); s0_if.araddr = $urandom; s0_if.arlen = 8'($urandom_range(0, 3));
      s1_if.arvalid = 1'($urandom_range(0, 1)); s1_if.araddr = $urandom; s1_if.arlen = 8'($urandom_range(0, 3));
      m_if.arready = ($urandom_range(0, 3) != 0);
      s0_if.rready = ($urandom_range(0, 3) != 0);
      s1_if.rready = ($urandom_range(0, 3) != 0);
      if (!rv && (q0.size() != 0 || q1.size() != 0) && $urandom_range(0, 2) != 0) begin
        if (q0.size() == 0) rsrc = 1;
        else if (q1.size() == 0) rsrc = 0;
        else rsrc = 1'($urandom_range(0, 1));
        rv = 1; rhi = 1'($urandom_range(0, 1)); rdat = $urandom;
      end
      if (rv) last = rsrc ? (q1[0] == 1) : (q0[0] == 1);
      else last = 0;
      m_if.rvalid = rv; m_if.rid = {rhi, rsrc}; m_if.rdata = rdat; m_if.rlast = last; m_if.rresp = 2'b00;
      e0 = s0_if.arvalid && (cnt[0] < OSTD);
      e1 = s1_if.arvalid && (cnt[1] < OSTD);
      g0 = !pend && e0 && (!e1 || !rr);
      g1 = !pend && e1 && (!e0 || rr);
      rdy = rsrc ? s1_if.rready : s0_if.rready;
      #1;
      checks++; if (m_if.arvalid !== pend) begin errors++; $display("FAIL rnd_arvalid cyc=%0d got=%b exp=%b", cyc, m_if.arvalid, pend); end
      if (pend) begin
        checks++; if (m_if.araddr !== paddr || m_if.arlen !== plen || m_if.arid !== 2'(psrc)) begin errors++; $display("FAIL rnd_ar_payload cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, m_if.araddr, m_if.arlen, m_if.arid, paddr, plen, 2'(psrc)); end
      end
      checks++; if (s0_if.arready !== g0 || s1_if.arready !== g1) begin errors++; $display("FAIL rnd_arready cyc=%0d got=%b%b exp=%b%b", cyc, s0_if.arready, s1_if.arready, g0, g1); end
      checks++; if (s0_if.rvalid !== (rv && !rsrc) || s1_if.rvalid !== (rv && rsrc)) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", cyc, s0_if.rvalid, s1_if.rvalid, rv && !rsrc, rv && rsrc); end
      if (rv) begin
        checks++; if (m_if.rready !== rdy) begin errors++; $display("FAIL rnd_rready cyc=%0d got=%b exp=%b", cyc, m_if.rready, rdy); end
        checks++; if ((rsrc ? s1_if.rdata : s0_if.rdata) !== rdat) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rsrc ? s1_if.rdata : s0_if.rdata, rdat); end
      end
      if (pend && m_if.arready) begin
        cnt[psrc]++;
        if (psrc) q1.push_back(int'(plen) + 1);
        else      q0.push_back(int'(plen) + 1);
        pend = 0;
      end else if (g0 || g1) begin
        pend = 1; psrc = g1;
        paddr = g1 ? s1_if.araddr : s0_if.araddr;
        plen  = g1 ? s1_if.arlen  : s0_if.arlen;
        if (e0 && e1) rr = !rr;
      end
      if (rv && rdy) begin
        if (rsrc) begin
          if (q1[0] == 1) begin void'(q1.pop_front()); cnt[1]--; end
          else q1[0] = q1[0] - 1;
        end else begin
          if (q0[0] == 1) begin void'(q0.pop_front()); cnt[0]--; end
          else q0[0] = q0[0] - 1;
        end
        rv = 0;
      end
      tick();
    end
    m_if.rvalid = 1'b0; s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_simultaneous();
    test_single_fetch();
    test_backpressure();
    test_r_backpressure();
    test_limit();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
